// File: rtl/spi_frame_master.sv
// Serialises a WIDTH-bit word MSB first onto a clock/chip-select/data link
// for a receive shifter that samples on rising master_clk while chip select is high.
module spi_frame_master #(
  parameter int unsigned WIDTH   = 48,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_word,
  output logic             busy,
  output logic             done,
  output logic             master_clk,
  output logic             master_chip_select,
  output logic             master_data
);

  localparam int unsigned PhW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [BitW-1:0]  bits;
  logic [PhW-1:0]   ph;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= StIdle;
      sh                 <= '0;
      bits               <= '0;
      ph                 <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      master_clk         <= 1'b0;
      master_chip_select <= 1'b0;
      master_data        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            sh                 <= tx_word;
            bits               <= '0;
            ph                 <= '0;
            busy               <= 1'b1;
            master_chip_select <= 1'b1;
            master_data        <= tx_word[WIDTH-1];
            state              <= StSetup;
          end
        end
        StSetup, StLow: begin
          if (ph == PhLast) begin
            ph         <= '0;
            master_clk <= 1'b1;
            state      <= StHigh;
          end else begin
            ph <= ph + PhW'(1);
          end
        end
        StHigh: begin
          if (ph == PhLast) begin
            ph         <= '0;
            master_clk <= 1'b0;
            bits       <= bits + BitW'(1);
            if (bits == BitLast) begin
              state <= StHold;
            end else begin
              // Next bit goes out together with the falling edge, a full half-period before rising
              sh          <= {sh[WIDTH-2:0], 1'b0};
              master_data <= sh[WIDTH-2];
              state       <= StLow;
            end
          end else begin
            ph <= ph + PhW'(1);
          end
        end
        StHold: begin
          if (ph == PhLast) begin
            ph                 <= '0;
            master_chip_select <= 1'b0;
            master_data        <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b1;
            state              <= StIdle;
          end else begin
            ph <= ph + PhW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
